// File: rtl/cmd_proc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_proc_gen
//  Description : Command processor for the Knight's-tour robot. Decodes
//                16-bit commands, sequences gyro calibration and
//                heading-aligned square moves with saturating speed ramps,
//                a stall watchdog and ACK/NAK responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_proc_gen #(
    parameter int FRWRD_W  = 10,
    parameter int HEAD_W   = 12,
    parameter int SQ_W     = 3,
    parameter int INC_STEP = 32,
    parameter int DEC_STEP = 64,
    parameter int MAX_SPD  = 768,
    parameter int HEAD_TOL = 48,
    parameter int NUDGE    = 511,
    parameter int TMO_RDY  = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              cmd,
    input  logic                     cmd_rdy,
    output logic                     clr_cmd_rdy,
    output logic                     send_resp,
    output logic [7:0]               resp,
    output logic                     strt_cal,
    input  logic                     cal_done,
    input  logic signed [HEAD_W-1:0] heading,
    input  logic                     heading_rdy,
    input  logic                     lftIR,
    input  logic                     cntrIR,
    input  logic                     rghtIR,
    output logic signed [HEAD_W-1:0] error,
    output logic [FRWRD_W-1:0]       frwrd,
    output logic                     moving,
    output logic                     tour_go,
    output logic                     fanfare_go,
    output logic                     fault
);

    localparam logic [7:0]                c_ACK     = 8'hA5;
    localparam logic [7:0]                c_NAK     = 8'h5A;
    localparam int                        c_WD_W    = $clog2(TMO_RDY + 1);
    localparam logic [FRWRD_W:0]          c_INC     = (FRWRD_W + 1)'(INC_STEP);
    localparam logic [FRWRD_W:0]          c_DEC     = (FRWRD_W + 1)'(DEC_STEP);
    localparam logic [FRWRD_W:0]          c_MAX     = (FRWRD_W + 1)'(MAX_SPD);
    localparam logic [HEAD_W-1:0]         c_NUDGE   = HEAD_W'(NUDGE);
    localparam logic signed [HEAD_W-1:0]  c_TOL     = HEAD_W'(HEAD_TOL);
    localparam logic [c_WD_W-1:0]         c_WD_LAST = c_WD_W'(TMO_RDY - 1);
    localparam logic [c_WD_W-1:0]         c_WD_ONE  = c_WD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAL   = 3'd1,
        S_ALIGN = 3'd2,
        S_MOVE  = 3'd3,
        S_STOP  = 3'd4,
        S_TOUR  = 3'd5
    } state_t;

    state_t              r_state;
    logic [15:0]         r_cmd_q;
    logic [HEAD_W-1:0]   r_desired;
    logic [FRWRD_W-1:0]  r_frwrd;
    logic [SQ_W:0]       r_count;
    logic [c_WD_W-1:0]   r_wdog;
    logic                r_cntr_q;
    logic                r_clr_cmd_rdy;
    logic                r_send_resp;
    logic                r_resp_blk;
    logic [7:0]          r_resp;
    logic                r_strt_cal;
    logic                r_tour_go;
    logic                r_fanfare_go;
    logic                r_fault;

    logic [HEAD_W-1:0]   w_nudge;
    logic                w_aligned;
    logic [FRWRD_W:0]    w_up_sum;
    logic [FRWRD_W:0]    w_dn_dif;
    logic [FRWRD_W-1:0]  w_frwrd_up;
    logic [FRWRD_W-1:0]  w_frwrd_dn;
    logic                w_rise;
    logic [SQ_W:0]       w_cnt_nxt;
    logic [SQ_W:0]       w_target;
    logic                w_wd_expire;
    logic                w_accept;
    logic                w_unused;

    // IR nudge: left sensor steers one way, right the other, left wins a tie
    always_comb begin
        w_nudge = '0;
        if (lftIR) begin
            w_nudge = c_NUDGE;
        end else if (rghtIR) begin
            w_nudge = -c_NUDGE;
        end
    end

    assign error     = heading - r_desired + w_nudge;
    assign w_aligned = (error > -c_TOL) && (error < c_TOL);

    // Ramps computed one bit wider so they clamp instead of wrapping
    assign w_up_sum   = {1'b0, r_frwrd} + c_INC;
    assign w_dn_dif   = {1'b0, r_frwrd} - c_DEC;
    assign w_frwrd_up = (w_up_sum > c_MAX) ? c_MAX[FRWRD_W-1:0] : w_up_sum[FRWRD_W-1:0];
    assign w_frwrd_dn = w_dn_dif[FRWRD_W] ? '0 : w_dn_dif[FRWRD_W-1:0];

    assign w_rise      = cntrIR & ~r_cntr_q;
    assign w_cnt_nxt   = r_count + {{SQ_W{1'b0}}, w_rise};
    assign w_target    = {r_cmd_q[SQ_W-1:0], 1'b0};
    assign w_wd_expire = heading_rdy && !w_rise && (r_wdog == c_WD_LAST);

    // Wrapper keeps cmd_rdy up until it sees clr_cmd_rdy, and a new command
    // must not be taken within two cycles of a response.
    assign w_accept = cmd_rdy && !r_clr_cmd_rdy && !r_send_resp && !r_resp_blk;

    assign w_unused = ^r_cmd_q;

    assign clr_cmd_rdy = r_clr_cmd_rdy;
    assign send_resp   = r_send_resp;
    assign resp        = r_resp;
    assign strt_cal    = r_strt_cal;
    assign frwrd       = r_frwrd;
    assign moving      = |r_frwrd;
    assign tour_go     = r_tour_go;
    assign fanfare_go  = r_fanfare_go;
    assign fault       = r_fault;

    // One-flop history of cntrIR for square-crossing edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cntr_q <= 1'b0;
        end else begin
            r_cntr_q <= cntrIR;
        end
    end

    // Command sequencer: decode, calibrate, align, ramp, stop, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cmd_q       <= '0;
            r_desired     <= '0;
            r_frwrd       <= '0;
            r_count       <= '0;
            r_wdog        <= '0;
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_resp_blk    <= 1'b0;
            r_resp        <= '0;
            r_strt_cal    <= 1'b0;
            r_tour_go     <= 1'b0;
            r_fanfare_go  <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_tour_go     <= 1'b0;
            r_fanfare_go  <= 1'b0;
            r_resp_blk    <= r_send_resp;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd_q       <= cmd;
                        r_clr_cmd_rdy <= 1'b1;
                        r_fault       <= 1'b0;
                        case (cmd[15:12])
                            4'd0: begin
                                r_strt_cal <= 1'b1;
                                r_state    <= S_CAL;
                            end
                            4'd2, 4'd3: begin
                                r_desired <= (cmd[11:4] == 8'd0) ? '0
                                           : {cmd[11:4], {(HEAD_W - 8){1'b1}}};
                                r_state   <= S_ALIGN;
                            end
                            4'd4: begin
                                r_state <= S_TOUR;
                            end
                            default: begin
                                r_send_resp <= 1'b1;
                                r_resp      <= c_NAK;
                            end
                        endcase
                    end
                end
                S_CAL: begin
                    if (cal_done) begin
                        r_strt_cal  <= 1'b0;
                        r_send_resp <= 1'b1;
                        r_resp      <= c_ACK;
                        r_state     <= S_IDLE;
                    end
                end
                S_ALIGN: begin
                    if (w_aligned) begin
                        if (r_cmd_q[SQ_W-1:0] == '0) begin
                            r_send_resp <= 1'b1;
                            r_resp      <= c_ACK;
                            r_state     <= S_IDLE;
                        end else begin
                            r_count <= '0;
                            r_wdog  <= '0;
                            r_state <= S_MOVE;
                        end
                    end
                end
                S_MOVE: begin
                    if (heading_rdy) begin
                        r_frwrd <= w_frwrd_up;
                    end
                    r_count <= w_cnt_nxt;
                    if (w_rise) begin
                        r_wdog <= '0;
                    end else if (heading_rdy) begin
                        r_wdog <= r_wdog + c_WD_ONE;
                    end
                    // Reaching the target takes precedence over a stall
                    if (w_cnt_nxt == w_target) begin
                        r_fanfare_go <= (r_cmd_q[15:12] == 4'd3);
                        r_state      <= S_STOP;
                    end else if (w_wd_expire) begin
                        r_fault <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_frwrd == '0) begin
                        r_send_resp <= 1'b1;
                        r_resp      <= r_fault ? c_NAK : c_ACK;
                        r_state     <= S_IDLE;
                    end else if (heading_rdy) begin
                        r_frwrd <= w_frwrd_dn;
                    end
                end
                S_TOUR: begin
                    r_tour_go <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
